// File: rtl/lcd1602_pkg.sv
// -----------------------------------------------------------------------------
// lcd1602_pkg
// Shared types and constants for the HD44780-class 16x2 LCD controller:
//   - lcd_state_t : sequencer states (ctrl and strobe engine share the enum)
//   - LCD_CMD_*   : init command bytes and DDRAM addressing constants
//   - is_long_cmd : commands that need the long execution wait
//   - init_cmd    : init command ROM lookup
//   - max_int     : helper used to size the shared cycle counters
// -----------------------------------------------------------------------------
package lcd1602_pkg;

  typedef enum logic [2:0] {
    ST_PWRUP,
    ST_INIT,
    ST_IDLE,
    ST_SETUP,
    ST_PULSE,
    ST_HOLD,
    ST_WAIT
  } lcd_state_t;

  localparam logic [7:0] LCD_CMD_FUNCSET = 8'h38;  // 8-bit bus, 2 lines, 5x8 font
  localparam logic [7:0] LCD_CMD_DISPON  = 8'h0C;  // display on, cursor off
  localparam logic [7:0] LCD_CMD_ENTRY   = 8'h06;  // increment, no shift
  localparam logic [7:0] LCD_CMD_CLEAR   = 8'h01;
  localparam logic [7:0] LCD_CMD_HOME    = 8'h02;
  localparam logic [7:0] LCD_CMD_DDRAM   = 8'h80;
  localparam logic [7:0] LCD_ROW1_OFS    = 8'h40;

  // Clear (0x01) and return-home (0x02/0x03) take ~1.5 ms on the panel.
  function automatic logic is_long_cmd(input logic [7:0] cmd);
    return (cmd[7:2] == 6'd0) && (cmd[1:0] != 2'd0);
  endfunction

  function automatic logic [7:0] init_cmd(input logic [1:0] idx);
    case (idx)
      2'd0:    return LCD_CMD_FUNCSET;
      2'd1:    return LCD_CMD_DISPON;
      2'd2:    return LCD_CMD_ENTRY;
      default: return LCD_CMD_CLEAR;
    endcase
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lcd1602_if.sv
// -----------------------------------------------------------------------------
// lcd1602_if
// Upstream write-request channel (valid/ready) into the LCD controller.
//   req_valid : request present          (master -> slave)
//   req_ready : controller can accept    (slave  -> master)
//   req_rs    : 1 = character, 0 = command
//   req_data  : command byte or ASCII character
// -----------------------------------------------------------------------------
interface lcd1602_if;
  logic       req_valid;
  logic       req_ready;
  logic       req_rs;
  logic [7:0] req_data;

  modport master (output req_valid, output req_rs, output req_data, input req_ready);
  modport slave  (input req_valid, input req_rs, input req_data, output req_ready);
endinterface

// File: rtl/lcd1602_strobe.sv
// -----------------------------------------------------------------------------
// lcd1602_strobe
// Bus-cycle engine for one LCD write: latches byte+rs on i_start, then runs
// SETUP -> PULSE (E high) -> HOLD -> WAIT (execution time) and returns to idle.
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   i_start       : one-cycle start pulse (accepted only when idle)
//   i_rs, i_data  : register select and byte to write
//   i_wait_cyc    : execution wait length, sampled at the end of HOLD
//   o_lcd_rs/en/dat : registered LCD pins
//   o_hold_end    : high in the last HOLD cycle
//   o_done        : high in the last WAIT cycle
// -----------------------------------------------------------------------------
module lcd1602_strobe
  import lcd1602_pkg::*;
#(
  parameter int SETUP_CYC = 4,
  parameter int PULSE_CYC = 16,
  parameter int HOLD_CYC  = 4,
  parameter int CW        = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_start,
  input  logic          i_rs,
  input  logic [7:0]    i_data,
  input  logic [CW-1:0] i_wait_cyc,
  output logic          o_lcd_rs,
  output logic          o_lcd_en,
  output logic [7:0]    o_lcd_dat,
  output logic          o_hold_end,
  output logic          o_done
);

  lcd_state_t    r_state, w_state_next;
  logic [CW-1:0] r_cnt, w_cnt_next;
  logic          r_en, w_en_next;
  logic          r_rs;
  logic [7:0]    r_dat;
  logic          w_load;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_en    <= 1'b0;
      r_rs    <= 1'b0;
      r_dat   <= 8'h00;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_en    <= w_en_next;
      if (w_load) begin
        r_rs  <= i_rs;
        r_dat <= i_data;
      end
    end
  end

  // Each phase loads r_cnt with (length-1) on entry and leaves when it hits 0,
  // so a phase of N lasts exactly N cycles.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_en_next    = r_en;
    w_load       = 1'b0;
    case (r_state)
      ST_SETUP: begin
        if (r_cnt == '0) begin
          w_state_next = ST_PULSE;
          w_cnt_next   = CW'(PULSE_CYC - 1);
          w_en_next    = 1'b1;
        end else begin
          w_cnt_next = r_cnt - CW'(1);
        end
      end
      ST_PULSE: begin
        if (r_cnt == '0) begin
          w_state_next = ST_HOLD;
          w_cnt_next   = CW'(HOLD_CYC - 1);
          w_en_next    = 1'b0;
        end else begin
          w_cnt_next = r_cnt - CW'(1);
        end
      end
      ST_HOLD: begin
        if (r_cnt == '0) begin
          w_state_next = ST_WAIT;
          w_cnt_next   = i_wait_cyc - CW'(1);
        end else begin
          w_cnt_next = r_cnt - CW'(1);
        end
      end
      ST_WAIT: begin
        if (r_cnt == '0) begin
          w_state_next = ST_IDLE;
        end else begin
          w_cnt_next = r_cnt - CW'(1);
        end
      end
      default: begin
        // Idle: rs/dat only ever change here, on the edge that enters SETUP.
        if (i_start) begin
          w_state_next = ST_SETUP;
          w_cnt_next   = CW'(SETUP_CYC - 1);
          w_load       = 1'b1;
        end
      end
    endcase
  end

  assign o_lcd_rs   = r_rs;
  assign o_lcd_en   = r_en;
  assign o_lcd_dat  = r_dat;
  assign o_hold_end = (r_state == ST_HOLD) && (r_cnt == '0);
  assign o_done     = (r_state == ST_WAIT) && (r_cnt == '0);

endmodule

// File: rtl/lcd1602_ctrl.sv
// -----------------------------------------------------------------------------
// lcd1602_ctrl
// Top-level 16x2 LCD sequencer: power-up delay, fixed init command sequence,
// then single command/character writes from upstream with cursor tracking and
// automatic DDRAM re-addressing when a character write wraps past column 15.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   req          : upstream valid/ready write channel (slave side)
//   lcd_rs/rw/en/dat : LCD pins (rw tied low)
//   init_done    : sticky, set once the init sequence has finished
//   cursor_row/col : tracked cursor position
// -----------------------------------------------------------------------------
module lcd1602_ctrl
  import lcd1602_pkg::*;
#(
  parameter int SETUP_CYC    = 4,
  parameter int PULSE_CYC    = 16,
  parameter int HOLD_CYC     = 4,
  parameter int CMD_WAIT_CYC = 2500,
  parameter int CLR_WAIT_CYC = 100000,
  parameter int PWRUP_CYC    = 2000000
) (
  input  logic       clk,
  input  logic       rst,
  lcd1602_if.slave   req,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_en,
  output logic [7:0] lcd_dat,
  output logic       init_done,
  output logic       cursor_row,
  output logic [3:0] cursor_col
);

  localparam int MAX_CYC = max_int(max_int(max_int(SETUP_CYC, PULSE_CYC), max_int(HOLD_CYC, CMD_WAIT_CYC)),
                                   max_int(CLR_WAIT_CYC, PWRUP_CYC));
  localparam int CW = $clog2(MAX_CYC) + 1;

  // ST_WAIT here means "a bus cycle is in flight in the strobe engine".
  lcd_state_t    r_state, w_state_next;
  logic [CW-1:0] r_pwr_cnt;
  logic [1:0]    r_init_idx;
  logic          r_init_done;
  logic          r_start;
  logic          r_rs;
  logic [7:0]    r_byte;
  logic          r_row;
  logic [3:0]    r_col;
  logic          r_wrap_pend;

  logic          w_issue, w_issue_rs;
  logic [7:0]    w_issue_byte;
  logic          w_init_step, w_init_last;
  logic          w_hold_end, w_done;
  logic [CW-1:0] w_wait_cyc;

  assign w_wait_cyc = (!r_rs && is_long_cmd(r_byte)) ? CW'(CLR_WAIT_CYC) : CW'(CMD_WAIT_CYC);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_PWRUP;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_issue      = 1'b0;
    w_issue_rs   = 1'b0;
    w_issue_byte = 8'h00;
    w_init_step  = 1'b0;
    w_init_last  = 1'b0;
    case (r_state)
      ST_PWRUP: begin
        if (r_pwr_cnt == CW'(PWRUP_CYC - 1)) w_state_next = ST_INIT;
      end
      ST_INIT: begin
        w_issue      = 1'b1;
        w_issue_byte = init_cmd(r_init_idx);
        w_state_next = ST_WAIT;
      end
      ST_IDLE: begin
        if (req.req_valid && r_init_done) begin
          w_issue      = 1'b1;
          w_issue_rs   = req.req_rs;
          w_issue_byte = req.req_data;
          w_state_next = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (w_done) begin
          if (r_wrap_pend) begin
            // Cursor row was already flipped at the wrapping write's HOLD end.
            w_issue      = 1'b1;
            w_issue_byte = LCD_CMD_DDRAM | (r_row ? LCD_ROW1_OFS : 8'h00);
          end else if (!r_init_done) begin
            if (r_init_idx == 2'd3) begin
              w_init_last  = 1'b1;
              w_state_next = ST_IDLE;
            end else begin
              w_init_step  = 1'b1;
              w_state_next = ST_INIT;
            end
          end else begin
            w_state_next = ST_IDLE;
          end
        end
      end
      default: w_state_next = ST_PWRUP;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pwr_cnt   <= '0;
      r_init_idx  <= 2'd0;
      r_init_done <= 1'b0;
      r_start     <= 1'b0;
      r_rs        <= 1'b0;
      r_byte      <= 8'h00;
      r_row       <= 1'b0;
      r_col       <= 4'd0;
      r_wrap_pend <= 1'b0;
    end else begin
      r_pwr_cnt <= (r_state == ST_PWRUP) ? r_pwr_cnt + CW'(1) : '0;
      r_start   <= w_issue;
      if (w_issue) begin
        r_rs   <= w_issue_rs;
        r_byte <= w_issue_byte;
      end
      if (w_init_step) r_init_idx <= r_init_idx + 2'd1;

      if (w_init_last) begin
        r_init_done <= 1'b1;
        r_row       <= 1'b0;
        r_col       <= 4'd0;
      end else if (w_hold_end) begin
        if (r_rs) begin
          if (r_col == 4'hF) begin
            r_row       <= ~r_row;
            r_col       <= 4'd0;
            r_wrap_pend <= 1'b1;
          end else begin
            r_col <= r_col + 4'd1;
          end
        end else if (is_long_cmd(r_byte)) begin
          r_row <= 1'b0;
          r_col <= 4'd0;
        end else if (r_byte[7]) begin
          r_row <= r_byte[6];
          r_col <= r_byte[3:0];
        end
      end

      if (w_done && r_wrap_pend) r_wrap_pend <= 1'b0;
    end
  end

  lcd1602_strobe #(
    .SETUP_CYC (SETUP_CYC),
    .PULSE_CYC (PULSE_CYC),
    .HOLD_CYC  (HOLD_CYC),
    .CW        (CW)
  ) u_strobe (
    .clk        (clk),
    .rst        (rst),
    .i_start    (r_start),
    .i_rs       (r_rs),
    .i_data     (r_byte),
    .i_wait_cyc (w_wait_cyc),
    .o_lcd_rs   (lcd_rs),
    .o_lcd_en   (lcd_en),
    .o_lcd_dat  (lcd_dat),
    .o_hold_end (w_hold_end),
    .o_done     (w_done)
  );

  assign req.req_ready = (r_state == ST_IDLE) && r_init_done;
  assign lcd_rw        = 1'b0;
  assign init_done     = r_init_done;
  assign cursor_row    = r_row;
  assign cursor_col    = r_col;

endmodule

// File: tb/tb_lcd1602_ctrl.sv
// -----------------------------------------------------------------------------
// tb_lcd1602_ctrl
// Directed bench for lcd1602_ctrl with small timing parameters: reset values,
// power-up/init sequence, single-character cycle timing, DDRAM set, clear,
// line wrap in both rows, backpressure, and reset in the middle of a pulse.
// -----------------------------------------------------------------------------
module tb_lcd1602_ctrl;

  localparam int SETUP = 2;
  localparam int PULSE = 3;
  localparam int HOLD  = 2;
  localparam int CMDW  = 5;
  localparam int CLRW  = 9;
  localparam int PWR   = 10;

  // Busy lengths (accept edge to ready-seen) derived by hand.
  localparam int BUSY_CMD  = SETUP + PULSE + HOLD + CMDW + 1;       // 13
  localparam int BUSY_CLR  = SETUP + PULSE + HOLD + CLRW + 1;       // 17
  localparam int BUSY_WRAP = BUSY_CMD + 1 + SETUP + PULSE + HOLD + CMDW; // 26

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       lcd_rs, lcd_rw, lcd_en, init_done, cursor_row;
  logic [7:0] lcd_dat;
  logic [3:0] cursor_col;

  lcd1602_if req_if ();

  lcd1602_ctrl #(
    .SETUP_CYC    (SETUP),
    .PULSE_CYC    (PULSE),
    .HOLD_CYC     (HOLD),
    .CMD_WAIT_CYC (CMDW),
    .CLR_WAIT_CYC (CLRW),
    .PWRUP_CYC    (PWR)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req_if),
    .lcd_rs     (lcd_rs),
    .lcd_rw     (lcd_rw),
    .lcd_en     (lcd_en),
    .lcd_dat    (lcd_dat),
    .init_done  (init_done),
    .cursor_row (cursor_row),
    .cursor_col (cursor_col)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // E-pulse monitor: records byte/rs at each rising edge of lcd_en, pulse
  // length at each falling edge, and any data change while E is high.
  logic [7:0] q_dat[$];
  logic       q_rs[$];
  int         q_len[$];
  int         q_rise[$];
  int         last_fall = 0;
  logic       m_prev = 1'b0;
  int         m_run = 0;
  logic [7:0] m_dat = 8'h00;
  int         stable_err = 0;

  always @(negedge clk) begin
    if (lcd_en && !m_prev) begin
      q_dat.push_back(lcd_dat);
      q_rs.push_back(lcd_rs);
      q_rise.push_back(cyc);
      m_dat = lcd_dat;
      m_run = 1;
    end else if (lcd_en) begin
      m_run = m_run + 1;
      if (lcd_dat !== m_dat) stable_err = stable_err + 1;
    end
    if (!lcd_en && m_prev) begin
      q_len.push_back(m_run);
      last_fall = cyc;
    end
    m_prev = lcd_en;
  end

  task automatic wait_ready(input string tag, input int max_cyc, output int at);
    at = -1;
    for (int k = 0; k < max_cyc; k++) begin
      if (req_if.req_ready === 1'b1) begin
        at = cyc;
        break;
      end
      @(posedge clk); #1;
    end
    check_eq({tag, "_in_time"}, 32'(at >= 0), 32'd1);
  endtask

  task automatic send(input string tag, input logic rs, input logic [7:0] d, input int exp_busy);
    int t_acc, t_rdy;
    wait_ready({tag, "_pre"}, 400, t_rdy);
    req_if.req_valid = 1'b1;
    req_if.req_rs    = rs;
    req_if.req_data  = d;
    @(posedge clk); #1;
    t_acc = cyc;
    req_if.req_valid = 1'b0;
    wait_ready({tag, "_post"}, 400, t_rdy);
    check_eq({tag, "_busy"}, 32'(t_rdy - t_acc), 32'(exp_busy));
    $display("TXN %s rs=%0d data=0x%02h busy=%0d cursor=(%0d,%0d)",
             tag, rs, d, t_rdy - t_acc, cursor_row, cursor_col);
  endtask

  task automatic power_up(input string tag);
    int c0, t, bd, bl, br;
    logic [7:0] exp_init [4];
    exp_init[0] = 8'h38; exp_init[1] = 8'h0C; exp_init[2] = 8'h06; exp_init[3] = 8'h01;
    @(posedge clk); #1;
    rst = 1'b0;
    c0 = cyc;
    bd = q_dat.size(); bl = q_len.size(); br = q_rise.size();
    wait_ready({tag, "_rdy"}, 300, t);
    check_eq({tag, "_npulse"}, 32'(q_dat.size() - bd), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (q_dat.size() > bd + i) begin
        check_eq($sformatf("%s_dat%0d", tag, i), 32'(q_dat[bd + i]), 32'(exp_init[i]));
        check_eq($sformatf("%s_rs%0d", tag, i), 32'(q_rs[bd + i]), 32'd0);
      end
      if (q_len.size() > bl + i)
        check_eq($sformatf("%s_len%0d", tag, i), 32'(q_len[bl + i]), 32'(PULSE));
    end
    if (q_rise.size() > br)
      check_eq({tag, "_quiet"}, 32'((q_rise[br] - c0) > PWR), 32'd1);
    check_eq({tag, "_clr_gap"}, 32'(t - last_fall), 32'(HOLD + CLRW));
    check_eq({tag, "_init_done"}, 32'(init_done), 32'd1);
    check_eq({tag, "_row"}, 32'(cursor_row), 32'd0);
    check_eq({tag, "_col"}, 32'(cursor_col), 32'd0);
    $display("TXN %s init complete at cycle %0d (released at %0d)", tag, t, c0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, bd, t_acc;
    logic exp_en, exp_rdy;

    req_if.req_valid = 1'b0;
    req_if.req_rs    = 1'b0;
    req_if.req_data  = 8'h00;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_en", 32'(lcd_en), 32'd0);
    check_eq("rst_rs", 32'(lcd_rs), 32'd0);
    check_eq("rst_rw", 32'(lcd_rw), 32'd0);
    check_eq("rst_dat", 32'(lcd_dat), 32'h00);
    check_eq("rst_ready", 32'(req_if.req_ready), 32'd0);
    check_eq("rst_init_done", 32'(init_done), 32'd0);
    check_eq("rst_row", 32'(cursor_row), 32'd0);
    check_eq("rst_col", 32'(cursor_col), 32'd0);

    power_up("pwr1");

    // Single character, cycle-by-cycle
    req_if.req_valid = 1'b1;
    req_if.req_rs    = 1'b1;
    req_if.req_data  = 8'h41;
    @(posedge clk); #1;
    t_acc = cyc;
    req_if.req_valid = 1'b0;
    req_if.req_data  = 8'hEE;
    for (int k = 1; k <= 13; k++) begin
      @(posedge clk); #1;
      exp_en  = (k >= 3) && (k <= 5);
      exp_rdy = (k == 13);
      check_eq($sformatf("char_en_T%0d", k), 32'(lcd_en), 32'(exp_en));
      check_eq($sformatf("char_rdy_T%0d", k), 32'(req_if.req_ready), 32'(exp_rdy));
      if (k <= 7) begin
        check_eq($sformatf("char_dat_T%0d", k), 32'(lcd_dat), 32'h41);
        check_eq($sformatf("char_rs_T%0d", k), 32'(lcd_rs), 32'd1);
      end
    end
    check_eq("char_col", 32'(cursor_col), 32'd1);
    $display("TXN char rs=1 data=0x41 accepted at %0d cursor=(%0d,%0d)", t_acc, cursor_row, cursor_col);

    // Set DDRAM and clear
    send("ddram_c5", 1'b0, 8'hC5, BUSY_CMD);
    check_eq("ddram_row", 32'(cursor_row), 32'd1);
    check_eq("ddram_col", 32'(cursor_col), 32'd5);
    send("clear", 1'b0, 8'h01, BUSY_CLR);
    check_eq("clear_row", 32'(cursor_row), 32'd0);
    check_eq("clear_col", 32'(cursor_col), 32'd0);

    // Wrap from row 0
    for (int i = 0; i < 15; i++) send($sformatf("r0c%0d", i), 1'b1, 8'h61 + 8'(i), BUSY_CMD);
    check_eq("r0_pre_col", 32'(cursor_col), 32'd15);
    bd = q_dat.size();
    send("r0_wrap", 1'b1, 8'h5A, BUSY_WRAP);
    check_eq("r0_wrap_npulse", 32'(q_dat.size() - bd), 32'd2);
    if (q_dat.size() >= bd + 2) begin
      check_eq("r0_wrap_char", 32'(q_dat[bd]), 32'h5A);
      check_eq("r0_wrap_char_rs", 32'(q_rs[bd]), 32'd1);
      check_eq("r0_wrap_auto", 32'(q_dat[bd + 1]), 32'hC0);
      check_eq("r0_wrap_auto_rs", 32'(q_rs[bd + 1]), 32'd0);
    end
    check_eq("r0_wrap_row", 32'(cursor_row), 32'd1);
    check_eq("r0_wrap_col", 32'(cursor_col), 32'd0);

    // Wrap from row 1
    for (int i = 0; i < 15; i++) send($sformatf("r1c%0d", i), 1'b1, 8'h41 + 8'(i), BUSY_CMD);
    bd = q_dat.size();
    send("r1_wrap", 1'b1, 8'h7A, BUSY_WRAP);
    check_eq("r1_wrap_npulse", 32'(q_dat.size() - bd), 32'd2);
    if (q_dat.size() >= bd + 2) begin
      check_eq("r1_wrap_char", 32'(q_dat[bd]), 32'h7A);
      check_eq("r1_wrap_auto", 32'(q_dat[bd + 1]), 32'h80);
      check_eq("r1_wrap_auto_rs", 32'(q_rs[bd + 1]), 32'd0);
    end
    check_eq("r1_wrap_row", 32'(cursor_row), 32'd0);
    check_eq("r1_wrap_col", 32'(cursor_col), 32'd0);

    // Backpressure: valid held high, data changing every cycle
    wait_ready("bp_pre", 400, t);
    bd = q_dat.size();
    req_if.req_rs    = 1'b1;
    req_if.req_valid = 1'b1;
    for (int i = 0; i < 30; i++) begin
      req_if.req_data = 8'h60 + 8'(i);
      @(posedge clk); #1;
    end
    req_if.req_valid = 1'b0;
    wait_ready("bp_post", 400, t);
    check_eq("bp_npulse", 32'(q_dat.size() - bd), 32'd3);
    if (q_dat.size() >= bd + 3) begin
      check_eq("bp_dat0", 32'(q_dat[bd]), 32'h60);
      check_eq("bp_dat1", 32'(q_dat[bd + 1]), 32'h6E);
      check_eq("bp_dat2", 32'(q_dat[bd + 2]), 32'h7C);
    end
    check_eq("bp_col", 32'(cursor_col), 32'd3);
    $display("TXN backpressure accepted %0d bytes cursor=(%0d,%0d)", q_dat.size() - bd, cursor_row, cursor_col);

    // Reset in the middle of an E pulse
    wait_ready("mid_pre", 400, t);
    req_if.req_valid = 1'b1;
    req_if.req_rs    = 1'b1;
    req_if.req_data  = 8'h5A;
    @(posedge clk); #1;
    req_if.req_valid = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (lcd_en === 1'b1) break;
      @(posedge clk); #1;
    end
    check_eq("mid_saw_en", 32'(lcd_en), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check_eq("mid_en", 32'(lcd_en), 32'd0);
    check_eq("mid_rs", 32'(lcd_rs), 32'd0);
    check_eq("mid_dat", 32'(lcd_dat), 32'h00);
    check_eq("mid_ready", 32'(req_if.req_ready), 32'd0);
    check_eq("mid_init_done", 32'(init_done), 32'd0);
    check_eq("mid_col", 32'(cursor_col), 32'd0);
    $display("TXN reset asserted during E pulse");

    power_up("pwr2");
    send("post_rst_char", 1'b1, 8'h42, BUSY_CMD);
    check_eq("post_rst_col", 32'(cursor_col), 32'd1);

    check_eq("dat_stable_in_pulse", 32'(stable_err), 32'd0);
    check_eq("rw_low", 32'(lcd_rw), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
